// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux
// Desc     : TDM serial link receiver. Recovers frame alignment from the sync
//            strobe and emits N_LANES-bit parallel words with a valid pulse.
//            Option macro: TDM_DEMUX_SYNC_CHECK_EN (strict per-frame sync).
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux #(
    parameter  int N_LANES = 4,
    localparam int SLOT_W  = $clog2(N_LANES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               din,
    input  logic               sync,
    output logic [N_LANES-1:0] data,
    output logic               valid,
    output logic [SLOT_W-1:0]  slot,
    output logic               locked,
    output logic               sync_err
);

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam logic c_SYNC_CHECK = 1'b1;
`else
    localparam logic c_SYNC_CHECK = 1'b0;
`endif

    localparam logic [0:0]        c_HUNT      = 1'b0;
    localparam logic [0:0]        c_RUN       = 1'b1;
    localparam logic [SLOT_W-1:0] c_SLOT_LAST = SLOT_W'(N_LANES - 1);
    localparam logic [SLOT_W-1:0] c_SLOT_ONE  = SLOT_W'(1);

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [SLOT_W-1:0]  r_slot;
    logic [SLOT_W-1:0]  w_slot_next;
    logic [N_LANES-1:0] r_lane;
    logic [N_LANES-1:0] r_data;
    logic               r_valid;
    logic               r_sync_err;
    logic               w_lane_we;
    logic [SLOT_W-1:0]  w_lane_idx;
    logic               w_done;
    logic               w_err;
    logic               w_slot_zero;

    assign w_slot_zero = (r_slot == '0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_HUNT: begin
                if (ce && sync) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (c_SYNC_CHECK && ce && !sync && w_slot_zero) begin
                    w_state_next = c_HUNT;
                end
            end
            default: w_state_next = c_HUNT;
        endcase
    end

    // Per-sample control decode
    always_comb begin
        w_slot_next = r_slot;
        w_lane_we   = 1'b0;
        w_lane_idx  = '0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            c_HUNT: begin
                if (ce && sync) begin
                    w_lane_we   = 1'b1;
                    w_slot_next = c_SLOT_ONE;
                end
            end
            c_RUN: begin
                if (ce) begin
                    if (sync && !w_slot_zero) begin
                        // Early sync: realign on this sample, drop the partial frame
                        w_err       = 1'b1;
                        w_lane_we   = 1'b1;
                        w_slot_next = c_SLOT_ONE;
                    end else if (c_SYNC_CHECK && !sync && w_slot_zero) begin
                        w_err       = 1'b1;
                        w_slot_next = '0;
                    end else begin
                        w_lane_we   = 1'b1;
                        w_lane_idx  = r_slot;
                        w_slot_next = r_slot + 1'b1;
                        w_done      = (r_slot == c_SLOT_LAST);
                    end
                end
            end
            default: w_slot_next = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot     <= '0;
            r_lane     <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_slot     <= w_slot_next;
            r_valid    <= w_done;
            r_sync_err <= w_err;
            if (w_lane_we) begin
                r_lane[w_lane_idx] <= din;
            end
            if (w_done) begin
                r_data <= {din, r_lane[N_LANES-2:0]};
            end
        end
    end

    assign data     = r_data;
    assign valid    = r_valid;
    assign slot     = r_slot;
    assign locked   = (r_state == c_RUN);
    assign sync_err = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux
// Desc     : Self-checking bench for tdm_demux against a queue-based frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

    localparam int N  = 4;
    localparam int SW = 2;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    localparam bit SYNC_CHECK = 1'b1;
`else
    localparam bit SYNC_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          din = 1'b0;
    logic          sync = 1'b0;
    logic [N-1:0]  data;
    logic          valid;
    logic [SW-1:0] slot;
    logic          locked;
    logic          sync_err;

    int n_checks = 0;
    int n_errors = 0;

    tdm_demux #(.N_LANES(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .ce       (ce),
        .din      (din),
        .sync     (sync),
        .data     (data),
        .valid    (valid),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // Frame model: the bits gathered so far in the current frame live in a queue
    bit           m_locked = 1'b0;
    bit           m_q[$];
    logic [N-1:0] m_data = '0;
    bit           m_valid = 1'b0;
    bit           m_err = 1'b0;

    task automatic model_step(input bit r, input bit c, input bit s, input bit d);
        if (r) begin
            m_locked = 1'b0;
            m_q.delete();
            m_data  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            return;
        end
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (!c) return;
        if (!m_locked) begin
            if (s) begin
                m_q.delete();
                m_q.push_back(d);
                m_locked = 1'b1;
            end
        end else if (s && m_q.size() != 0) begin
            m_err = 1'b1;
            m_q.delete();
            m_q.push_back(d);
        end else if (!s && m_q.size() == 0 && SYNC_CHECK) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
        end else begin
            m_q.push_back(d);
            if (m_q.size() == N) begin
                for (int i = 0; i < N; i++) m_data[i] = m_q[i];
                m_valid = 1'b1;
                m_q.delete();
            end
        end
    endtask

    function automatic logic [N+SW+2:0] exp_vec();
        logic [SW-1:0] s;
        s = m_locked ? SW'(m_q.size()) : '0;
        return {m_data, m_valid, s, m_locked, m_err};
    endfunction

    // Apply one clock of stimulus, then return #1 after the sampling edge
    task automatic drive(input bit r, input bit c, input bit s, input bit d);
        @(negedge clk);
        rst = r; ce = c; sync = s; din = d;
        model_step(r, c, s, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0);
        drive(1, 1, 1, 1);
        if ({data, valid, slot, locked, sync_err} !== '0) begin
            n_errors++;
            $display("FAIL reset: got %b exp 0", {data, valid, slot, locked, sync_err});
        end
        n_checks++;
    endtask

    task automatic test_basic_frame();
        bit s_seq[4] = '{1, 0, 0, 0};
        bit d_seq[4] = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, s_seq[i], d_seq[i]);
            if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                n_errors++;
                $display("FAIL basic step %0d: got %b exp %b", i, {data, valid, slot, locked, sync_err}, exp_vec());
            end
            n_checks++;
            if (locked !== 1'b1) begin
                n_errors++;
                $display("FAIL basic locked step %0d: got %b exp 1", i, locked);
            end
            n_checks++;
        end
        if (data !== 4'b1101 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL basic word: got data=%b valid=%b exp data=1101 valid=1", data, valid);
        end
        n_checks++;
        drive(0, 0, 0, 0);
        if (valid !== 1'b0 || data !== 4'b1101) begin
            n_errors++;
            $display("FAIL basic valid width: got data=%b valid=%b exp data=1101 valid=0", data, valid);
        end
        n_checks++;
    endtask

    task automatic test_ce_gap();
        bit s_seq[4] = '{1, 0, 0, 0};
        bit d_seq[4] = '{1, 0, 1, 1};
        int nv = 0;
        for (int i = 0; i < 4; i++) begin
            for (int ph = 0; ph < 2; ph++) begin
                drive(0, ph[0], s_seq[i], d_seq[i]);
                if (valid === 1'b1) nv++;
                if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL ce_gap step %0d.%0d: got %b exp %b", i, ph, {data, valid, slot, locked, sync_err}, exp_vec());
                end
                n_checks++;
            end
        end
        if (nv != 1 || data !== 4'b1101) begin
            n_errors++;
            $display("FAIL ce_gap word: got valids=%0d data=%b exp valids=1 data=1101", nv, data);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] words[3] = '{4'hA, 4'h5, 4'hF};
        logic [3:0] w;
        for (int f = 0; f < 3; f++) begin
            w = words[f];
            for (int b = 0; b < 4; b++) begin
                drive(0, 1, b == 0, w[b]);
                if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                    n_errors++;
                    $display("FAIL b2b f%0d b%0d: got %b exp %b", f, b, {data, valid, slot, locked, sync_err}, exp_vec());
                end
                n_checks++;
                if (valid !== (b == 3)) begin
                    n_errors++;
                    $display("FAIL b2b spacing f%0d b%0d: got valid=%b exp %b", f, b, valid, b == 3);
                end
                n_checks++;
            end
            if (data !== w) begin
                n_errors++;
                $display("FAIL b2b data f%0d: got %h exp %h", f, data, w);
            end
            n_checks++;
        end
    endtask

    task automatic test_early_sync();
        int nv = 0;
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 1);
        if (sync_err !== 1'b1 || valid !== 1'b0 || slot !== 2'd1) begin
            n_errors++;
            $display("FAIL early_sync pulse: got err=%b valid=%b slot=%0d exp err=1 valid=0 slot=1", sync_err, valid, slot);
        end
        n_checks++;
        for (int b = 0; b < 3; b++) begin
            drive(0, 1, 0, b[0]);
            if (valid === 1'b1) nv++;
            if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                n_errors++;
                $display("FAIL early_sync step %0d: got %b exp %b", b, {data, valid, slot, locked, sync_err}, exp_vec());
            end
            n_checks++;
        end
        if (nv != 1 || data !== 4'b0101) begin
            n_errors++;
            $display("FAIL early_sync word: got valids=%0d data=%b exp valids=1 data=0101", nv, data);
        end
        n_checks++;
    endtask

    task automatic test_missing_sync();
        bit d_seq[4] = '{1, 1, 0, 0};
        int nv = 0;
        for (int b = 0; b < 4; b++) begin
            drive(0, 1, 0, d_seq[b]);
            if (valid === 1'b1) nv++;
            if (b == 0 && (sync_err !== SYNC_CHECK || locked !== !SYNC_CHECK)) begin
                n_errors++;
                $display("FAIL missing_sync first: got err=%b locked=%b exp err=%b locked=%b", sync_err, locked, SYNC_CHECK, !SYNC_CHECK);
            end
            if (b == 0) n_checks++;
            if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                n_errors++;
                $display("FAIL missing_sync step %0d: got %b exp %b", b, {data, valid, slot, locked, sync_err}, exp_vec());
            end
            n_checks++;
        end
        if (nv != (SYNC_CHECK ? 0 : 1) || (!SYNC_CHECK && data !== 4'b0011)) begin
            n_errors++;
            $display("FAIL missing_sync word: got valids=%0d data=%b exp valids=%0d", nv, data, SYNC_CHECK ? 0 : 1);
        end
        n_checks++;
    endtask

    task automatic test_reset_midframe();
        bit d_seq[4] = '{1, 0, 1, 1};
        int nv = 0;
        drive(0, 1, 1, 1);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 1);
        if ({data, valid, slot, locked, sync_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: got %b exp 0", {data, valid, slot, locked, sync_err});
        end
        n_checks++;
        for (int b = 0; b < 5; b++) begin
            drive(0, 1, 0, $urandom_range(0, 1) == 1);
            if (valid === 1'b1 || locked === 1'b1) nv++;
        end
        if (nv != 0) begin
            n_errors++;
            $display("FAIL reset_mid unsynced: got %0d active cycles exp 0", nv);
        end
        n_checks++;
        for (int b = 0; b < 4; b++) begin
            drive(0, 1, b == 0, d_seq[b]);
            if (valid !== (b == 3)) begin
                n_errors++;
                $display("FAIL reset_mid relock b%0d: got valid=%b exp %b", b, valid, b == 3);
            end
            n_checks++;
        end
        if (data !== 4'b1101) begin
            n_errors++;
            $display("FAIL reset_mid word: got %b exp 1101", data);
        end
        n_checks++;
    endtask

    task automatic test_random();
        bit r, c, s, d;
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 127) == 0);
            c = ($urandom_range(0, 3) != 0);
            if (m_q.size() == 0) s = ($urandom_range(0, 7) != 0);
            else                 s = ($urandom_range(0, 15) == 0);
            d = $urandom_range(0, 1) == 1;
            drive(r, c, s, d);
            if ({data, valid, slot, locked, sync_err} !== exp_vec()) begin
                n_errors++;
                $display("FAIL random cyc %0d: got %b exp %b", i, {data, valid, slot, locked, sync_err}, exp_vec());
            end
            n_checks++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_ce_gap();
        test_back_to_back();
        test_early_sync();
        test_missing_sync();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
